// File: rtl/cpu_defs_pkg.sv
// Definitions shared by the fetch stage and the instruction decoder:
// opcode type field values, the bubble instruction word and PC defaults.
package cpu_defs_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b101010;
  localparam logic [OPC_W-1:0] OPC_VLD   = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_VSD   = 6'b101011;
  localparam logic [OPC_W-1:0] OPC_VBEZ  = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_VBNEZ = 6'b000101;
  localparam logic [OPC_W-1:0] OPC_VNOP  = 6'b111100;

  // Bubble: VNOP type field in the top bits, everything else zero.
  localparam logic [31:0] VNOP_INST = {OPC_VNOP, 26'd0};

  localparam int DEF_PC_W    = 32;
  localparam int DEF_PC_STEP = 4;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying instruction, PC and valid between two stages.
// Priority: reset, then flush (load a bubble), then stall (hold), then load.
module if_id_reg #(
  parameter int          PC_W      = cpu_defs_pkg::DEF_PC_W,
  parameter logic [31:0] VNOP_INST = cpu_defs_pkg::VNOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic [31:0]     fetch_inst,
  input  logic [PC_W-1:0] fetch_pc,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] pc,
  output logic            valid
);

  logic [31:0]     inst_reg;
  logic [PC_W-1:0] pc_reg;
  logic            valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_reg  <= VNOP_INST;
      pc_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (flush) begin
      // The squashed slot still records the PC it would have carried.
      inst_reg  <= VNOP_INST;
      pc_reg    <= fetch_pc;
      valid_reg <= 1'b0;
    end else if (!stall) begin
      inst_reg  <= fetch_inst;
      pc_reg    <= fetch_pc;
      valid_reg <= 1'b1;
    end
  end

  assign inst  = inst_reg;
  assign pc    = pc_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN sequencing, fetch counter,
// and the IF/ID register feeding the decoder.
module fetch_stage
  import cpu_defs_pkg::*;
#(
  parameter int              PC_W      = DEF_PC_W,
  parameter int              PC_STEP   = DEF_PC_STEP,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     VNOP_INST = cpu_defs_pkg::VNOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] IF_imem_addr,
  input  logic [31:0]     IF_imem_data,
  input  logic            ID_stall,
  input  logic            ID_br_taken,
  input  logic [PC_W-1:0] ID_br_target,
  output logic [31:0]     ID_inst,
  output logic [PC_W-1:0] ID_pc,
  output logic            ID_valid,
  output logic [15:0]     IF_fetch_cnt
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(STEP - 1'b1);

  logic [0:0]      state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [15:0]     fetch_cnt_reg;
  logic            in_run;
  logic            redirect;
  logic            advance;

  // Branch and stall requests only take effect once the pipeline is running.
  assign in_run   = (state_reg == RUN);
  assign redirect = in_run && ID_br_taken;
  assign advance  = in_run && !ID_br_taken && !ID_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= BOOT;
      pc_reg        <= RESET_PC;
      fetch_cnt_reg <= '0;
    end else begin
      state_reg <= RUN;
      if (redirect) begin
        pc_reg <= ID_br_target & ALIGN_MASK;
      end else if (advance) begin
        pc_reg        <= pc_reg + STEP;
        fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
      end
    end
  end

  if_id_reg #(
    .PC_W      (PC_W),
    .VNOP_INST (VNOP_INST)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .stall      (!advance),
    .fetch_inst (IF_imem_data),
    .fetch_pc   (pc_reg),
    .inst       (ID_inst),
    .pc         (ID_pc),
    .valid      (ID_valid)
  );

  assign IF_imem_addr = pc_reg;
  assign IF_fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset/boot, stall, branch, reset during
// stall, PC wrap, target alignment and fetch-counter wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        valid;
  logic [15:0] fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] BUBBLE = 32'hF000_0000;

  always #5 clk = ~clk;

  // Instruction memory: word i at byte address 4i is A800_0000 | i.
  assign imem_data = 32'hA800_0000 | (imem_addr >> 2);

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .IF_imem_addr (imem_addr),
    .IF_imem_data (imem_data),
    .ID_stall     (stall),
    .ID_br_taken  (br_taken),
    .ID_br_target (br_target),
    .ID_inst      (inst),
    .ID_pc        (pc),
    .ID_valid     (valid),
    .IF_fetch_cnt (fetch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] e_addr,
                            input logic [31:0] e_inst, input logic [31:0] e_pc,
                            input logic e_valid, input logic [15:0] e_cnt);
    chk($sformatf("%s.addr", tag), imem_addr, e_addr);
    chk($sformatf("%s.inst", tag), inst, e_inst);
    chk($sformatf("%s.pc", tag), pc, e_pc);
    chk($sformatf("%s.valid", tag), {31'd0, valid}, {31'd0, e_valid});
    chk($sformatf("%s.cnt", tag), {16'd0, fetch_cnt}, {16'd0, e_cnt});
    $display("%0t %s addr=%08h inst=%08h pc=%08h valid=%0b cnt=%0d",
             $time, tag, imem_addr, inst, pc, valid, fetch_cnt);
  endtask

  initial begin
    logic [15:0] exp_cnt;
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    tick(); tick();
    expect_all("reset", 32'h0, BUBBLE, 32'h0, 1'b0, 16'd0);

    reset = 1'b0;
    expect_all("boot", 32'h0, BUBBLE, 32'h0, 1'b0, 16'd0);
    tick();
    expect_all("boot_edge", 32'h0, BUBBLE, 32'h0, 1'b0, 16'd0);
    tick();
    expect_all("run1", 32'h4, 32'hA800_0000, 32'h0, 1'b1, 16'd1);
    tick();
    expect_all("run2", 32'h8, 32'hA800_0001, 32'h4, 1'b1, 16'd2);

    // Stall three edges with PC = 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_all($sformatf("stall%0d", i), 32'h8, 32'hA800_0001, 32'h4, 1'b1, 16'd2);
    end
    stall = 1'b0;
    tick();
    expect_all("unstall", 32'hC, 32'hA800_0002, 32'h8, 1'b1, 16'd3);
    tick();
    expect_all("run3", 32'h10, 32'hA800_0003, 32'hC, 1'b1, 16'd4);

    // Taken branch at PC = 0x10 to 0x40
    br_taken = 1'b1; br_target = 32'h40;
    tick();
    expect_all("br", 32'h40, BUBBLE, 32'h10, 1'b0, 16'd4);
    br_taken = 1'b0;
    tick();
    expect_all("br_tgt", 32'h44, 32'hA800_0010, 32'h40, 1'b1, 16'd5);

    // Branch together with stall: redirect wins
    br_taken = 1'b1; stall = 1'b1; br_target = 32'h20;
    tick();
    expect_all("br_stall", 32'h20, BUBBLE, 32'h44, 1'b0, 16'd5);
    br_taken = 1'b0; stall = 1'b0;
    tick();
    expect_all("br_stall_tgt", 32'h24, 32'hA800_0008, 32'h20, 1'b1, 16'd6);
    tick(); tick(); tick();
    expect_all("run4", 32'h30, 32'hA800_000B, 32'h2C, 1'b1, 16'd9);

    // Reset pulse during a stall at PC = 0x30
    stall = 1'b1;
    tick();
    expect_all("stall_30", 32'h30, 32'hA800_000B, 32'h2C, 1'b1, 16'd9);
    reset = 1'b1;
    tick();
    expect_all("reset2", 32'h0, BUBBLE, 32'h0, 1'b0, 16'd0);
    // Requests during BOOT are ignored
    reset = 1'b0; br_taken = 1'b1; br_target = 32'h80;
    tick();
    expect_all("boot2", 32'h0, BUBBLE, 32'h0, 1'b0, 16'd0);
    stall = 1'b0; br_taken = 1'b0;
    tick();
    expect_all("run_after_reset", 32'h4, 32'hA800_0000, 32'h0, 1'b1, 16'd1);

    // PC wrap from 0xFFFF_FFFC to 0
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    expect_all("br_top", 32'hFFFF_FFFC, BUBBLE, 32'h4, 1'b0, 16'd1);
    br_taken = 1'b0;
    tick();
    expect_all("pc_wrap", 32'h0, 32'hBFFF_FFFF, 32'hFFFF_FFFC, 1'b1, 16'd2);

    // Misaligned target is truncated to the word boundary
    br_taken = 1'b1; br_target = 32'h43;
    tick();
    expect_all("br_align", 32'h40, BUBBLE, 32'h0, 1'b0, 16'd2);
    br_taken = 1'b0;
    tick();
    expect_all("align_tgt", 32'h44, 32'hA800_0010, 32'h40, 1'b1, 16'd3);

    // Run the fetch counter up to 0xFFFF and through the wrap
    exp_cnt = 16'd3;
    while (exp_cnt != 16'hFFFF) begin
      tick();
      exp_cnt = exp_cnt + 16'd1;
    end
    chk("cnt_max", {16'd0, fetch_cnt}, 32'h0000_FFFF);
    $display("%0t cnt_max cnt=%0d", $time, fetch_cnt);
    tick();
    chk("cnt_wrap", {16'd0, fetch_cnt}, 32'h0);
    $display("%0t cnt_wrap cnt=%0d", $time, fetch_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage and IF/ID pipeline register of the 5-stage vector CPU.
- Sits directly upstream of the instruction decoder and feeds it the 32-bit instruction word (bit 0 = MSB).
- Holds the PC and drives the instruction-memory address. Handles stalls from hazard detection and redirects from branches resolved in ID.
- Inserts VNOP bubbles after reset and on a taken branch.

Parameters:
- PC_W, 32, width of the PC and the instruction-memory address.
- PC_STEP, 4, byte increment per sequential fetch.
- RESET_PC, 0, PC value loaded on reset.
- VNOP_INST, 32'hF000_0000, bubble word: type field 6'b111100, all other bits 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- IF_imem_addr  output  PC_W  instruction-memory address; equals PC.
- IF_imem_data  input  32  instruction word; combinational read of IF_imem_addr in the same cycle.
- ID_stall  input  1  hazard unit request: hold PC and IF/ID contents.
- ID_br_taken  input  1  branch in ID is taken this cycle (from VBEZ/VBNEZ resolution).
- ID_br_target  input  PC_W  branch target byte address.
- ID_inst  output  32  IF/ID instruction register; drives the decoder.
- ID_pc  output  PC_W  PC of the instruction in ID_inst.
- ID_valid  output  1  1 when ID_inst is a real fetched instruction; 0 when it is a bubble.
- IF_fetch_cnt  output  16  count of instructions accepted into IF/ID; wraps modulo 2^16.

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high. Nothing changes state except on the rising edge of clk.
- Reset values:
  - PC = RESET_PC
  - ID_inst = VNOP_INST
  - ID_pc = 0
  - ID_valid = 0
  - IF_fetch_cnt = 0
  - state = BOOT
- States:
  - BOOT: exactly one cycle after reset deassertion. IF/ID holds the bubble; PC is not advanced; imem is addressed with RESET_PC. Next state is RUN.
  - RUN: normal operation. Never left except by reset.
- RUN update priority per edge, highest first:
  1. reset → reset values above.
  2. ID_br_taken=1 → PC <= ID_br_target; ID_inst <= VNOP_INST; ID_valid <= 0; ID_pc <= PC. Taken wins over a simultaneous ID_stall, and the wrong-path instruction is squashed.
  3. ID_stall=1 → PC, ID_inst, ID_pc, ID_valid and IF_fetch_cnt all hold.
  4. Otherwise → ID_inst <= IF_imem_data; ID_pc <= PC; ID_valid <= 1; PC <= PC + PC_STEP; IF_fetch_cnt <= IF_fetch_cnt + 1.
- In BOOT, ID_br_taken and ID_stall are ignored.
- Latency: the word at address A appears on ID_inst one edge after PC==A with no stall. Branch penalty is exactly one bubble.
- PC arithmetic: modulo 2^PC_W; wraps from 2^PC_W − PC_STEP to 0 silently.
- ID_br_target is used as given. Bits below log2(PC_STEP) are forced to 0 when loaded.
- Reset asserted mid-stall or mid-redirect: reset wins and all pending effects are discarded.
- IF_imem_addr is a pure function of the PC register; it has no combinational path from any input.

Decomposition:
- Shared cpu_defs package/include holds:
  - opcode type constants (RTYPE, VLD, VSD, VBEZ, VBNEZ, VNOP) and VNOP_INST, common with the decoder;
  - the PC_W / PC_STEP defaults.
- One natural sub-module, if_id_reg: the IF/ID pipeline register with stall, flush and valid. It is reused for later pipeline registers.
- PC logic and the BOOT/RUN FSM stay in fetch_stage.

Test Plan:
- Reset release, imem returns word i = 32'hA800_0000|i at byte address 4i:
  - cycle 1 (BOOT): ID_valid=0, ID_inst=F000_0000, IF_imem_addr=0.
  - cycle 2: ID_inst=A800_0000, ID_pc=0, IF_imem_addr=4.
  - IF_fetch_cnt reaches 3 after three RUN cycles.
- ID_stall=1 for 3 cycles while PC=8:
  - IF_imem_addr stays 8; ID_inst/ID_pc/IF_fetch_cnt frozen.
  - First edge after stall drops: ID_inst=word 2, ID_pc=8.
- ID_br_taken=1 with target 0x40 while PC=0x10:
  - next edge gives PC=0x40, ID_valid=0, ID_inst=F000_0000.
  - following edge gives ID_inst=word 16, ID_pc=0x40.
- ID_br_taken=1 and ID_stall=1 together, target 0x20: redirect applied; PC=0x20 and a bubble in IF/ID.
- Reset pulsed for 1 cycle during a stall at PC=0x30: all outputs return to reset values, then the BOOT then RUN sequence repeats from address 0.
- Wrap-around:
  - PC preset via branch to 0xFFFF_FFFC: after one advance PC=0.
  - IF_fetch_cnt forced through 0xFFFF wraps to 0.
  - Target 0x43 loads as 0x40.
